// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter in front of the shared
// registered ALU. Requester 0 is the execute stage, requester 1 is the
// branch/address-generation unit. Grants are combinational in the current
// cycle. The ALU's registered result comes back one cycle later and is
// strobed to the requester that was granted. The CPU-wide halt freezes
// all arbiter state and suppresses grants and response strobes.
module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              halt,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OP_W-1:0]   req0_op,
   input  logic              req0_signed,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req1_op,
   input  logic              req1_signed,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              rsp0_valid,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_carry,
   output logic              rsp_zero,
   output logic [OP_W-1:0]   alu_op_val,
   output logic              alu_signed_unsigned_n,
   output logic [DATA_W-1:0] alu_operand_a,
   output logic [DATA_W-1:0] alu_operand_b,
   input  logic [DATA_W-1:0] alu_result_out,
   input  logic              alu_carry_flag,
   input  logic              alu_zero_flag
);

   // last_grant resets to 1 so requester 0 wins the first tie.
   logic last_grant;
   logic pend_valid;
   logic pend_id;
   logic grant0;
   logic grant1;
   logic any_grant;

   // Round-robin arbitration: a lone requester wins, on a tie the one not
   // granted last wins, nothing is granted while halted.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (halt) begin
         grant0 = 1'b0;
         grant1 = 1'b0;
      end else if (req0_valid && req1_valid) begin
         grant0 = last_grant;
         grant1 = ~last_grant;
      end else begin
         grant0 = req0_valid;
         grant1 = req1_valid;
      end
   end

   assign any_grant  = grant0 | grant1;
   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Mux the granted requester onto the ALU; drive zeros when idle so the
   // ALU computes a harmless zero result.
   always_comb begin
      alu_op_val            = '0;
      alu_signed_unsigned_n = 1'b0;
      alu_operand_a         = '0;
      alu_operand_b         = '0;
      if (grant0) begin
         alu_op_val            = req0_op;
         alu_signed_unsigned_n = req0_signed;
         alu_operand_a         = req0_a;
         alu_operand_b         = req0_b;
      end else if (grant1) begin
         alu_op_val            = req1_op;
         alu_signed_unsigned_n = req1_signed;
         alu_operand_a         = req1_a;
         alu_operand_b         = req1_b;
      end else begin
         alu_op_val            = '0;
         alu_signed_unsigned_n = 1'b0;
         alu_operand_a         = '0;
         alu_operand_b         = '0;
      end
   end

   // Track which requester owns the in-flight ALU result and the fairness
   // pointer; everything freezes while halted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         pend_valid <= 1'b0;
         pend_id    <= 1'b0;
      end else if (!halt) begin
         pend_valid <= any_grant;
         pend_id    <= grant1;
         if (any_grant) begin
            last_grant <= grant1;
         end else begin
            last_grant <= last_grant;
         end
      end else begin
         last_grant <= last_grant;
         pend_valid <= pend_valid;
         pend_id    <= pend_id;
      end
   end

   // Response strobes come from registered ownership state; the halt gate
   // delays delivery to the first unhalted cycle.
   assign rsp0_valid = pend_valid & ~pend_id & ~halt;
   assign rsp1_valid = pend_valid &  pend_id & ~halt;

   // Result and flags pass straight through from the ALU's own registers.
   assign rsp_result = alu_result_out;
   assign rsp_carry  = alu_carry_flag;
   assign rsp_zero   = alu_zero_flag;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a small registered ALU model.
// ALU op encoding used here: 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, others -> 0.
module tb_alu_arbiter;

   localparam int DATA_W = 32;
   localparam int OP_W   = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              halt;
   logic              req0_valid, req1_valid;
   logic              req0_ready, req1_ready;
   logic [OP_W-1:0]   req0_op, req1_op;
   logic              req0_signed, req1_signed;
   logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic              rsp0_valid, rsp1_valid;
   logic [DATA_W-1:0] rsp_result;
   logic              rsp_carry, rsp_zero;
   logic [OP_W-1:0]   alu_op_val;
   logic              alu_signed_unsigned_n;
   logic [DATA_W-1:0] alu_operand_a, alu_operand_b;
   logic [DATA_W-1:0] alu_result_out;
   logic              alu_carry_flag, alu_zero_flag;

   int n_cmp = 0;
   int n_bad = 0;

   alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
      .clk(clk), .rst_n(rst_n), .halt(halt),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_signed(req0_signed), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_signed(req1_signed), .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
      .alu_op_val(alu_op_val), .alu_signed_unsigned_n(alu_signed_unsigned_n),
      .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
      .alu_result_out(alu_result_out), .alu_carry_flag(alu_carry_flag),
      .alu_zero_flag(alu_zero_flag)
   );

   always #5 clk = ~clk;

   // Registered ALU model; frozen by halt like the rest of the CPU.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_result_out <= 32'd0;
         alu_carry_flag <= 1'b0;
         alu_zero_flag  <= 1'b1;
      end else if (!halt) begin
         logic [DATA_W:0] t;
         case (alu_op_val)
            4'd1: t = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
            4'd2: t = {1'b0, alu_operand_a} - {1'b0, alu_operand_b};
            4'd3: t = {1'b0, alu_operand_a & alu_operand_b};
            4'd4: t = {1'b0, alu_operand_a | alu_operand_b};
            4'd5: t = alu_signed_unsigned_n ?
                      {32'd0, ($signed(alu_operand_a) < $signed(alu_operand_b))} :
                      {32'd0, (alu_operand_a < alu_operand_b)};
            default: t = 33'd0;
         endcase
         alu_result_out <= t[DATA_W-1:0];
         alu_carry_flag <= t[DATA_W];
         alu_zero_flag  <= (t[DATA_W-1:0] == 32'd0);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req0_op = 4'd0; req0_signed = 1'b0; req0_a = 32'd0; req0_b = 32'd0;
      req1_valid = 1'b0; req1_op = 4'd0; req1_signed = 1'b0; req1_a = 32'd0; req1_b = 32'd0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ready0"}, 32'(req0_ready), 32'd0);
      check({tag, "_ready1"}, 32'(req1_ready), 32'd0);
      check({tag, "_rsp0"}, 32'(rsp0_valid), 32'd0);
      check({tag, "_rsp1"}, 32'(rsp1_valid), 32'd0);
   endtask

   task automatic check_alu_idle(input string tag);
      check({tag, "_op"}, 32'(alu_op_val), 32'd0);
      check({tag, "_sgn"}, 32'(alu_signed_unsigned_n), 32'd0);
      check({tag, "_a"}, alu_operand_a, 32'd0);
      check({tag, "_b"}, alu_operand_b, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      halt  = 1'b0;
      idle_inputs();
      settle();
      // Reset values
      check_quiet("rst");
      check_alu_idle("rst");
      cyc(); cyc();
      rst_n = 1'b1;

      // Single add: 5 + 7
      cyc();
      req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'd5; req0_b = 32'd7;
      settle();
      check("add_ready0", 32'(req0_ready), 32'd1);
      check("add_ready1", 32'(req1_ready), 32'd0);
      check("add_alu_op", 32'(alu_op_val), 32'd1);
      check("add_alu_a", alu_operand_a, 32'd5);
      check("add_alu_b", alu_operand_b, 32'd7);
      cyc();
      idle_inputs();
      settle();
      check("add_rsp0", 32'(rsp0_valid), 32'd1);
      check("add_rsp1", 32'(rsp1_valid), 32'd0);
      check("add_result", rsp_result, 32'd12);
      check("add_zero", 32'(rsp_zero), 32'd0);

      // Halt mid-flight: req1 OR F0|0F, then halt for three cycles
      cyc();
      req1_valid = 1'b1; req1_op = 4'd4; req1_a = 32'h0000_00F0; req1_b = 32'h0000_000F;
      settle();
      check("or_ready1", 32'(req1_ready), 32'd1);
      check("or_ready0", 32'(req0_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         idle_inputs();
         halt = 1'b1;
         // a request arriving during halt must not be granted
         req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'd1; req0_b = 32'd1;
         settle();
         check_quiet("halt");
         check("halt_result_held", rsp_result, 32'h0000_00FF);
      end
      cyc();
      halt = 1'b0;
      idle_inputs();
      settle();
      check("halt_rel_rsp1", 32'(rsp1_valid), 32'd1);
      check("halt_rel_rsp0", 32'(rsp0_valid), 32'd0);
      check("halt_rel_result", rsp_result, 32'h0000_00FF);

      // Contention: r0 SUB 3-3, r1 SLT -1<2, both valid for 6 cycles
      for (int i = 0; i < 6; i++) begin
         cyc();
         req0_valid = 1'b1; req0_op = 4'd2; req0_signed = 1'b1; req0_a = 32'd3; req0_b = 32'd3;
         req1_valid = 1'b1; req1_op = 4'd5; req1_signed = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'd2;
         settle();
         check("cont_ready0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         check("cont_ready1", 32'(req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
         if (i > 0) begin
            check("cont_rsp0", 32'(rsp0_valid), (i % 2 == 1) ? 32'd1 : 32'd0);
            check("cont_rsp1", 32'(rsp1_valid), (i % 2 == 1) ? 32'd0 : 32'd1);
            check("cont_result", rsp_result, (i % 2 == 1) ? 32'd0 : 32'd1);
            check("cont_zero", 32'(rsp_zero), (i % 2 == 1) ? 32'd1 : 32'd0);
         end
      end
      cyc();
      idle_inputs();
      settle();
      check("cont_last_rsp1", 32'(rsp1_valid), 32'd1);
      check("cont_last_result", rsp_result, 32'd1);

      // Idle drive
      cyc();
      settle();
      check_quiet("idle");
      check_alu_idle("idle");

      // Op 0 from req0 is forwarded and yields a zero result
      cyc();
      req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd9; req0_b = 32'd4;
      settle();
      check("op0_ready0", 32'(req0_ready), 32'd1);
      check("op0_alu_op", 32'(alu_op_val), 32'd0);
      check("op0_alu_a", alu_operand_a, 32'd9);
      cyc();
      idle_inputs();
      settle();
      check("op0_rsp0", 32'(rsp0_valid), 32'd1);
      check("op0_result", rsp_result, 32'd0);
      check("op0_zero", 32'(rsp_zero), 32'd1);
      check("op0_carry", 32'(rsp_carry), 32'd0);

      // Fairness: req1 alone twice, then both -> requester 0
      for (int i = 0; i < 2; i++) begin
         cyc();
         idle_inputs();
         req1_valid = 1'b1; req1_op = 4'd3; req1_a = 32'hFF; req1_b = 32'h0F;
         settle();
         check("fair_solo_ready1", 32'(req1_ready), 32'd1);
      end
      cyc();
      req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'd2; req0_b = 32'd2;
      settle();
      check("fair_ready0", 32'(req0_ready), 32'd1);
      check("fair_ready1", 32'(req1_ready), 32'd0);
      check("fair_rsp1_prev", 32'(rsp1_valid), 32'd1);
      check("fair_and_result", rsp_result, 32'h0000_000F);

      // Reset mid-operation: grant req0 (last_grant -> 0), then reset
      cyc();
      idle_inputs();
      req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'd1; req0_b = 32'd1;
      settle();
      check("rmid_ready0", 32'(req0_ready), 32'd1);
      cyc();
      rst_n = 1'b0;
      idle_inputs();
      settle();
      check_quiet("rmid_in_rst");
      check_alu_idle("rmid_in_rst");
      cyc();
      rst_n = 1'b1;
      settle();
      check_quiet("rmid_rel");
      cyc();
      settle();
      check_quiet("rmid_rel2");
      cyc();
      req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'd4; req0_b = 32'd4;
      req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'd8; req1_b = 32'd8;
      settle();
      check("rmid_tie_ready0", 32'(req0_ready), 32'd1);
      check("rmid_tie_ready1", 32'(req1_ready), 32'd0);
      cyc();
      idle_inputs();
      settle();
      check("rmid_tie_rsp0", 32'(rsp0_valid), 32'd1);
      check("rmid_tie_result", rsp_result, 32'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
